// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with a 2-state request/ready bus and a registered irq.
// Optional MTIMER_SHADOW_EN: a read of mtime lo latches mtime hi so a following hi read is carry-atomic.
module mtimer #(
   parameter logic [63:0] CMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter logic [63:0] MTIME_RESET = 64'h0
) (
   input  logic        clk,
   input  logic        res,
   input  logic        tick,
   input  logic        sel,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        irq
);

   localparam int unsigned XLEN = 64;
   localparam int unsigned WLEN = 32;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } state_e;

   state_e            state_q;
   logic [XLEN-1:0]   mtime_q, mtime_d;
   logic [XLEN-1:0]   cmp_q, cmp_d;
   logic [WLEN-1:0]   rdata_q, rdata_d;
   logic [WLEN-1:0]   rd_val;
   logic              ready_q;
   logic              irq_q;
   logic              accept, wr, rd;
`ifdef MTIMER_SHADOW_EN
   logic [WLEN-1:0]   shadow_q, shadow_d;
`endif

   // Next-state for registers; a write to an mtime half overrides (and drops) a same-cycle tick.
   always_comb begin
      accept  = (state_q == S_IDLE) && sel;
      wr      = accept && we;
      rd      = accept && !we;

      mtime_d = mtime_q;
      if (wr && (addr == 2'd0))      mtime_d[WLEN-1:0]    = wdata;
      else if (wr && (addr == 2'd1)) mtime_d[XLEN-1:WLEN] = wdata;
      else if (tick)                 mtime_d              = mtime_q + XLEN'(1);

      cmp_d = cmp_q;
      if (wr && (addr == 2'd2))      cmp_d[WLEN-1:0]    = wdata;
      else if (wr && (addr == 2'd3)) cmp_d[XLEN-1:WLEN] = wdata;

      case (addr)
         2'd0:    rd_val = mtime_q[WLEN-1:0];
`ifdef MTIMER_SHADOW_EN
         2'd1:    rd_val = shadow_q;
`else
         2'd1:    rd_val = mtime_q[XLEN-1:WLEN];
`endif
         2'd2:    rd_val = cmp_q[WLEN-1:0];
         default: rd_val = cmp_q[XLEN-1:WLEN];
      endcase

      rdata_d = rd ? rd_val : '0;

`ifdef MTIMER_SHADOW_EN
      shadow_d = shadow_q;
      if (rd && (addr == 2'd0))      shadow_d = mtime_q[XLEN-1:WLEN];
      else if (wr && (addr == 2'd1)) shadow_d = wdata;
`endif
   end

   // Bus FSM, registers and registered outputs.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q  <= S_IDLE;
         mtime_q  <= MTIME_RESET;
         cmp_q    <= CMP_RESET;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
         irq_q    <= 1'b0;
`ifdef MTIMER_SHADOW_EN
         shadow_q <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE:  state_q <= sel ? S_ACK : S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         mtime_q  <= mtime_d;
         cmp_q    <= cmp_d;
         rdata_q  <= rdata_d;
         ready_q  <= accept;
         irq_q    <= (mtime_q >= cmp_q);
`ifdef MTIMER_SHADOW_EN
         shadow_q <= shadow_d;
`endif
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign irq   = irq_q;

endmodule

// File: tb/tb_mtimer.sv
// Scoreboard bench for mtimer: stimulus queues expected bus responses, a negedge monitor checks them.
module tb_mtimer;

   logic        clk;
   logic        res;
   logic        tick;
   logic        sel;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        irq;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_ready  = 0;

   mtimer dut (
      .clk   (clk),
      .res   (res),
      .tick  (tick),
      .sel   (sel),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .ready (ready),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every ready pulse consumes one queued access; reads compare rdata.
   always @(negedge clk) begin
      if (res && ready) begin
         exp_t e;
         n_ready++;
         if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            if (e.is_read) check(e.name, rdata, e.data);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive one access and return #1 after the accepting edge.
   task automatic bus_issue(input logic w, input logic [1:0] a, input logic [31:0] d,
                            input logic t, input string name);
      exp_t e;
      e.is_read = !w;
      e.data    = d;
      e.name    = name;
      exp_q.push_back(e);
      sel = 1'b1; we = w; addr = a; wdata = w ? d : 32'h0; tick = t;
      cyc();
      sel = 1'b0; we = 1'b0; tick = 1'b0;
   endtask

   task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d, input string name);
      bus_issue(w, a, d, 1'b0, name);
      cyc();
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      res = 1'b0; tick = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'h0;
      cyc(); cyc();
      res = 1'b1;
      cyc();

      // Reset state
      check("reset_irq",   32'(irq),   32'd0);
      check("reset_ready", 32'(ready), 32'd0);
      bus(1'b0, 2'd0, 32'h0000_0000, "reset_mtime_lo");
      bus(1'b0, 2'd1, 32'h0000_0000, "reset_mtime_hi");
      bus(1'b0, 2'd2, 32'hFFFF_FFFF, "reset_cmp_lo");
      bus(1'b0, 2'd3, 32'hFFFF_FFFF, "reset_cmp_hi");

      // Count to mtimecmp = 5; irq rises one edge after the 5th tick edge
      bus(1'b1, 2'd2, 32'd5, "wr_cmp_lo");
      bus(1'b1, 2'd3, 32'd0, "wr_cmp_hi");
      for (int i = 0; i < 5; i++) begin
         pulse_tick();
         check($sformatf("irq_at_tick%0d", i + 1), 32'(irq), 32'd0);
         cyc();
         check($sformatf("irq_after_tick%0d", i + 1), 32'(irq), (i == 4) ? 32'd1 : 32'd0);
      end
      bus(1'b0, 2'd0, 32'd5, "count_mtime_lo");

      // Raising mtimecmp clears irq one cycle after the write edge
      bus_issue(1'b1, 2'd2, 32'd100, 1'b0, "wr_cmp_100");
      check("clear_irq_at_edge", 32'(irq), 32'd1);
      cyc();
      check("clear_irq_after", 32'(irq), 32'd0);
      bus(1'b0, 2'd0, 32'd5, "clear_mtime_lo");
      bus(1'b0, 2'd1, 32'd0, "clear_mtime_hi");

      // Carry from lo into hi
      bus(1'b1, 2'd0, 32'hFFFF_FFFF, "wr_carry_lo");
      pulse_tick();
      bus(1'b0, 2'd1, 32'd1, "carry_hi");
      bus(1'b0, 2'd0, 32'd0, "carry_lo");

      // 64-bit wrap; irq follows compare (0 < 100)
      bus(1'b1, 2'd1, 32'hFFFF_FFFF, "wr_wrap_hi");
      bus(1'b1, 2'd0, 32'hFFFF_FFFF, "wr_wrap_lo");
      check("wrap_irq_before", 32'(irq), 32'd1);
      pulse_tick();
      cyc();
      check("wrap_irq_after", 32'(irq), 32'd0);
      bus(1'b0, 2'd0, 32'd0, "wrap_lo");
      bus(1'b0, 2'd1, 32'd0, "wrap_hi");

      // Write collides with tick: write wins, tick dropped
      bus_issue(1'b1, 2'd0, 32'd42, 1'b1, "wr_collide");
      cyc();
      bus(1'b0, 2'd0, 32'd42, "collide_lo");
      bus(1'b0, 2'd1, 32'd0, "collide_hi");

      // sel held four cycles yields exactly two accesses
      begin
         exp_t e;
         e.is_read = 1'b1; e.data = 32'd100; e.name = "held_sel_rd1";
         exp_q.push_back(e);
         e.name = "held_sel_rd2";
         exp_q.push_back(e);
      end
      r0 = n_ready;
      sel = 1'b1; we = 1'b0; addr = 2'd2;
      cyc(); cyc(); cyc(); cyc();
      sel = 1'b0;
      cyc(); cyc();
      check("held_sel_ready_pulses", 32'(n_ready - r0), 32'd2);

      // Carry between a lo read and a hi read
      bus(1'b1, 2'd1, 32'd0, "wr_sh_hi");
      bus(1'b1, 2'd0, 32'hFFFF_FFFF, "wr_sh_lo");
      bus(1'b0, 2'd0, 32'hFFFF_FFFF, "shadow_lo");
      pulse_tick();
`ifdef MTIMER_SHADOW_EN
      bus(1'b0, 2'd1, 32'd0, "shadow_hi");
`else
      bus(1'b0, 2'd1, 32'd1, "live_hi");
`endif

      // Reset in the middle of an access aborts it
      bus_issue(1'b1, 2'd0, 32'd7, 1'b0, "wr_aborted");
      res = 1'b0;
      #1;
      check("midreset_ready", 32'(ready), 32'd0);
      check("midreset_rdata", rdata, 32'd0);
      void'(exp_q.pop_back());
      cyc();
      res = 1'b1;
      cyc();
      bus(1'b0, 2'd0, 32'd0, "post_reset_lo");
      bus(1'b0, 2'd2, 32'hFFFF_FFFF, "post_reset_cmp_lo");

      cyc(); cyc();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
